stream_demux_1_4: RTL and testbench
===================================

STREAM_DEMUX_1_4 -- requirements
Module: stream_demux_1_4

Interface
REQ-001 Parameter: WIDTH, default 4, payload width in bits.
REQ-002 Parameter: CNT_W, default 8, per-channel transfer counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 up_valid  input  1  upstream word present.
REQ-006 up_ready  output  1  upstream word accepted this cycle when up_valid also high.
REQ-007 up_sel  input  2  destination channel 0..3 for the current upstream word.
REQ-008 up_data  input  WIDTH  upstream payload.
REQ-009 down_valid  output  4  bit i: channel i holds a word.
REQ-010 down_ready  input  4  bit i: channel i consumer takes the word this cycle.
REQ-011 down_data  output  4*WIDTH  channel i payload at bits [i*WIDTH +: WIDTH].
REQ-012 down_count  output  4*CNT_W  channel i completed-transfer count at bits [i*CNT_W +: CNT_W].

Function
REQ-013 Each channel i SHALL own one output register: full flag (drives down_valid[i]), data register, counter.
REQ-014 Upstream handshake SHALL occur in a cycle where up_valid=1 and up_ready=1.
REQ-015 Downstream handshake on channel i SHALL occur in a cycle where down_valid[i]=1 and down_ready[i]=1.
REQ-016 up_ready SHALL be combinational: !full[up_sel] || down_ready[up_sel]; it SHALL NOT depend on up_valid.
REQ-017 On upstream handshake, channel up_sel SHALL be loaded with up_data and set full at the next edge: latency 1 cycle.
REQ-018 Only channel up_sel SHALL be affected by an upstream handshake; other channels' data and full flags SHALL hold.
REQ-019 On downstream handshake on channel i without a simultaneous load into i, full[i] SHALL clear at the next edge.
REQ-020 Simultaneous downstream handshake on channel i and upstream load into i SHALL leave full[i]=1 with the new word; no bubble, no loss.
REQ-021 down_data[i] SHALL hold stable while down_valid[i]=1 and down_ready[i]=0.
REQ-022 down_valid[i] SHALL never deassert without a downstream handshake on i (outside reset).
REQ-023 Independent channels SHALL drain concurrently: any subset of the 4 downstream handshakes may occur in one cycle.
REQ-024 A full channel whose down_ready is low SHALL stall only words addressed to it; up_ready reflects the currently selected channel.
REQ-025 down_count[i] SHALL increment by 1 on each downstream handshake on i, wrapping modulo 2^CNT_W (255 -> 0 at defaults).
REQ-026 Per-channel word order SHALL equal upstream acceptance order; one word stored per channel maximum.
REQ-027 up_sel and up_data SHALL be ignored when up_valid=0.

Reset
REQ-028 rst assertion SHALL immediately, without clock, clear all full flags (down_valid=4'b0000), all data registers to 0, all counters to 0.
REQ-029 During rst, up_ready SHALL read 1 (all channels empty); no handshake SHALL take effect while rst=1.
REQ-030 rst asserted mid-operation SHALL discard stored words; first accepted word after release SHALL appear 1 cycle later as on a fresh start.
REQ-031 Reset release SHALL be synchronous to clk by the integrating system; the block adds no synchronizer.

Verification
REQ-032 Basic route: up_valid=1, up_sel=2, up_data=4'hA, down_ready=0 -> next cycle down_valid=4'b0100, channel 2 data=4'hA, up_ready=0 while up_sel=2, up_ready=1 for up_sel=0.
REQ-033 Back-to-back pass-through: down_ready=4'hF, words 1,2,3,4 to channel 1 on consecutive cycles -> channel 1 outputs 1,2,3,4 on consecutive cycles, up_ready constantly 1, down_count[1]=4.
REQ-034 Stall isolation: channel 0 full with 4'h5, down_ready[0]=0 held 5 cycles; words 6,7 sent to channel 3 -> channel 3 delivers 6 then 7, channel 0 data stays 4'h5, down_valid[0] stays 1.
REQ-035 Simultaneous drain/refill: channel 2 holds 4'h3, down_ready[2]=1 and upstream 4'h9 to channel 2 same cycle -> next cycle down_valid[2]=1, data 4'h9, count[2] incremented by 1.
REQ-036 Counter wrap: 256 transfers on channel 0 at CNT_W=8 -> down_count[0] reads 255 after the 255th, 0 after the 256th.
REQ-037 Async reset: all four channels full, rst pulsed between clock edges -> down_valid=0, down_data=0, down_count=0 before next edge; then word 4'hC to channel 1 -> down_valid=4'b0010 one cycle later.

Source files
------------

// File: rtl/stream_demux_1_4.sv
// stream_demux_1_4: routes one upstream stream into four single-entry output registers,
// each with its own valid/ready handshake and a wrapping completed-transfer counter.
module stream_demux_1_4 #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 up_valid,
   output logic                 up_ready,
   input  logic [1:0]           up_sel,
   input  logic [WIDTH-1:0]     up_data,
   output logic [3:0]           down_valid,
   input  logic [3:0]           down_ready,
   output logic [4*WIDTH-1:0]   down_data,
   output logic [4*CNT_W-1:0]   down_count
);
   logic [3:0]                  full_q, full_d, drain;
   logic [3:0][WIDTH-1:0]       data_q, data_d;
   logic [3:0][CNT_W-1:0]       cnt_q, cnt_d;
   logic                        load;
   assign up_ready   = !full_q[up_sel] || down_ready[up_sel];
   assign load       = up_valid && up_ready;
   assign drain      = full_q & down_ready;
   assign down_valid = full_q;
   assign down_data  = data_q;
   assign down_count = cnt_q;
   // a drain and a load on the same channel in one cycle keeps it full with the new word
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      cnt_d  = cnt_q;
      for (int i = 0; i < 4; i++) begin
         full_d[i] = (load && up_sel == 2'(i)) || (full_q[i] && !drain[i]);
         data_d[i] = (load && up_sel == 2'(i)) ? up_data : data_q[i];
         cnt_d[i]  = cnt_q[i] + CNT_W'(drain[i]);
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= '0;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: tb/tb_stream_demux_1_4.sv
// tb_stream_demux_1_4: directed scenarios plus random traffic against a per-channel queue model.
module tb_stream_demux_1_4;
   localparam int W  = 4;
   localparam int CW = 8;
   logic            clk = 0, rst = 1, up_valid = 0, up_ready;
   logic [1:0]      up_sel = 0;
   logic [W-1:0]    up_data = 0;
   logic [3:0]      down_valid, down_ready = 0;
   logic [4*W-1:0]  down_data;
   logic [4*CW-1:0] down_count;
   int n_chk = 0, n_err = 0;
   int q[4][$];
   int m_last[4], m_cnt[4];

   stream_demux_1_4 #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready), .up_sel(up_sel),
      .up_data(up_data), .down_valid(down_valid), .down_ready(down_ready),
      .down_data(down_data), .down_count(down_count));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         q[i].delete();
         m_last[i] = 0;
         m_cnt[i]  = 0;
      end
   endtask

   function automatic bit exp_ready();
      return q[up_sel].size() == 0 || down_ready[up_sel];
   endfunction

   task automatic check_model();
      check("up_ready", up_ready, exp_ready());
      for (int i = 0; i < 4; i++) begin
         check($sformatf("valid%0d", i), down_valid[i], q[i].size() != 0);
         check($sformatf("data%0d", i), down_data[i*W +: W], q[i].size() != 0 ? q[i][0] : m_last[i]);
         check($sformatf("count%0d", i), down_count[i*CW +: CW], m_cnt[i]);
      end
   endtask

   task automatic drive(input bit uv, input bit [1:0] s, input bit [W-1:0] d, input bit [3:0] dr);
      @(negedge clk);
      up_valid = uv; up_sel = s; up_data = d; down_ready = dr;
      #1 check_model();
   endtask

   task automatic tick();
      bit acc;
      acc = up_valid && exp_ready();
      @(posedge clk);
      for (int i = 0; i < 4; i++)
         if (q[i].size() != 0 && down_ready[i]) begin
            void'(q[i].pop_front());
            m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
         end
      if (acc) begin
         q[up_sel].push_back(int'(up_data));
         m_last[up_sel] = int'(up_data);
      end
   endtask

   // reset asserted between clock edges and released before the next rising edge
   task automatic pulse_reset();
      @(negedge clk);
      up_valid = 0; down_ready = 0;
      #1 rst = 1;
      #1 model_clear();
      check("rst_valid", down_valid, 4'b0000);
      check("rst_data", down_data, '0);
      check("rst_count", down_count, '0);
      check("rst_ready", up_ready, 1'b1);
      #1 rst = 0;
   endtask

   initial begin
      model_clear();
      #2 check("por_valid", down_valid, 4'b0000);
      check("por_ready", up_ready, 1'b1);
      up_valid = 1; down_ready = 4'hF;
      @(posedge clk); #1;
      check("no_hs_in_rst", down_valid, 4'b0000);
      up_valid = 0;
      @(negedge clk) rst = 0;
      // basic route
      drive(1, 2, 4'hA, 4'h0); tick();
      drive(0, 2, 4'h0, 4'h0);
      check("route_valid", down_valid, 4'b0100);
      check("route_data2", down_data[2*W +: W], 4'hA);
      check("route_rdy_sel2", up_ready, 1'b0);
      tick();
      drive(0, 0, 4'h0, 4'h0);
      check("route_rdy_sel0", up_ready, 1'b1);
      tick();
      // back-to-back pass-through on channel 1
      pulse_reset();
      for (int k = 1; k <= 4; k++) begin
         drive(1, 1, 4'(k), 4'hF);
         check("b2b_ready", up_ready, 1'b1);
         if (k > 1) check("b2b_data1", down_data[W +: W], 4'(k - 1));
         tick();
      end
      drive(0, 1, 4'h0, 4'hF); tick();
      drive(0, 1, 4'h0, 4'hF);
      check("b2b_count1", down_count[CW +: CW], 8'd4);
      tick();
      // stall isolation
      pulse_reset();
      drive(1, 0, 4'h5, 4'h0); tick();
      drive(1, 3, 4'h6, 4'h0); tick();
      drive(1, 3, 4'h7, 4'b1000);
      check("iso_data3a", down_data[3*W +: W], 4'h6);
      tick();
      drive(0, 0, 4'h0, 4'b1000);
      check("iso_data3b", down_data[3*W +: W], 4'h7);
      check("iso_ready0", up_ready, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin drive(0, 3, 4'h0, 4'h0); tick(); end
      drive(0, 0, 4'h0, 4'h0);
      check("iso_valid0", down_valid[0], 1'b1);
      check("iso_data0", down_data[W-1:0], 4'h5);
      tick();
      // simultaneous drain and refill
      pulse_reset();
      drive(1, 2, 4'h3, 4'h0); tick();
      drive(1, 2, 4'h9, 4'b0100);
      check("refill_ready", up_ready, 1'b1);
      tick();
      drive(0, 0, 4'h0, 4'h0);
      check("refill_valid2", down_valid[2], 1'b1);
      check("refill_data2", down_data[2*W +: W], 4'h9);
      check("refill_count2", down_count[2*CW +: CW], 8'd1);
      tick();
      // counter wrap on channel 0
      pulse_reset();
      for (int k = 0; k <= 256; k++) begin
         drive(k < 256, 0, 4'(k), 4'hF);
         if (k == 256) check("wrap_255", down_count[CW-1:0], 8'd255);
         tick();
      end
      drive(0, 0, 4'h0, 4'hF);
      check("wrap_0", down_count[CW-1:0], 8'd0);
      tick();
      // async reset with all channels full
      for (int i = 0; i < 4; i++) begin drive(1, 2'(i), 4'(i + 1), 4'h0); tick(); end
      drive(0, 0, 4'h0, 4'h0);
      check("full_all", down_valid, 4'hF);
      pulse_reset();
      drive(1, 1, 4'hC, 4'h0); tick();
      drive(0, 0, 4'h0, 4'h0);
      check("post_rst_valid", down_valid, 4'b0010);
      check("post_rst_data1", down_data[W +: W], 4'hC);
      tick();
      // random traffic
      for (int k = 0; k < 2000; k++) begin
         drive($urandom_range(0, 3) != 0, 2'($urandom), 4'($urandom), 4'($urandom));
         tick();
         if (k == 1000) pulse_reset();
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
